// File: rtl/pipeline_stall_controller_if.sv
// pipeline_stall_controller_if: hazard inputs, pipeline control outputs and statistics of the stall controller.
interface pipeline_stall_controller_if #(
    parameter int CNT_W = 16
);
    logic             load_use;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             stats_clr;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             pipe_hold;
    logic             mem_wb_bubble;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_timeout;
    modport master (
        output load_use, branch_taken, mem_req, mem_ready, stats_clr,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold,
               mem_wb_bubble, state, stall_cnt, flush_cnt, mem_timeout
    );
    modport slave (
        input  load_use, branch_taken, mem_req, mem_ready, stats_clr,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold,
               mem_wb_bubble, state, stall_cnt, flush_cnt, mem_timeout
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: merges load-use, taken-branch and data-memory wait into pipeline enables/flushes/bubbles.
module pipeline_stall_controller #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input logic                          clk,
    input logic                          rst,
    pipeline_stall_controller_if.slave   bus
);
    typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, ERROR = 2'b10} state_t;
    state_t           r_state, w_next;
    logic [7:0]       r_wait_cnt, w_wait_nxt;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic             r_timeout;
    logic             w_hold, w_set_to, w_mem_stall, w_pc_write, w_if_id_flush;
    assign w_mem_stall = bus.mem_req & ~bus.mem_ready;
    always_comb begin
        w_next     = r_state;
        w_wait_nxt = r_wait_cnt;
        w_hold     = 1'b0;
        w_set_to   = 1'b0;
        case (r_state)
            RUN: begin
                w_hold     = w_mem_stall;
                w_next     = w_mem_stall ? MEM_WAIT : RUN;
                w_wait_nxt = w_mem_stall ? 8'd1 : 8'd0;
            end
            MEM_WAIT: begin
                // mem_req dropping counts as completion, so only a live unfinished request keeps the hold
                w_hold     = w_mem_stall;
                w_set_to   = w_mem_stall && (r_wait_cnt == 8'(MEM_TIMEOUT));
                w_next     = !w_mem_stall ? RUN : w_set_to ? ERROR : MEM_WAIT;
                w_wait_nxt = !w_mem_stall ? 8'd0 : w_set_to ? r_wait_cnt : r_wait_cnt + 8'd1;
            end
            ERROR: w_hold = 1'b1;
            default: begin
                w_next     = RUN;
                w_wait_nxt = 8'd0;
            end
        endcase
    end
    // Outputs follow rst combinationally so the pipeline is frozen while reset is held
    assign w_pc_write        = rst & ~w_hold & ~bus.load_use;
    assign w_if_id_flush     = rst & ~w_hold & ~bus.load_use & bus.branch_taken;
    assign bus.pc_write      = w_pc_write;
    assign bus.if_id_write   = w_pc_write;
    assign bus.if_id_flush   = w_if_id_flush;
    assign bus.id_ex_bubble  = rst & ~w_hold & bus.load_use;
    assign bus.pipe_hold     = ~rst | w_hold;
    assign bus.mem_wb_bubble = rst & w_hold;
    assign bus.state         = r_state;
    assign bus.stall_cnt     = r_stall_cnt;
    assign bus.flush_cnt     = r_flush_cnt;
    assign bus.mem_timeout   = r_timeout;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_wait_cnt  <= 8'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_wait_cnt  <= w_wait_nxt;
            r_timeout   <= r_timeout | w_set_to;
            r_stall_cnt <= bus.stats_clr ? '0 : (!w_pc_write && r_stall_cnt != '1) ? r_stall_cnt + CNT_W'(1) : r_stall_cnt;
            r_flush_cnt <= bus.stats_clr ? '0 : (w_if_id_flush && r_flush_cnt != '1) ? r_flush_cnt + CNT_W'(1) : r_flush_cnt;
        end
    end
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: directed scenario tests of the stall controller at CNT_W=16 and CNT_W=4.
module tb_pipeline_stall_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    always #5 clk = ~clk;
    pipeline_stall_controller_if #(.CNT_W(16)) a ();
    pipeline_stall_controller_if #(.CNT_W(4))  b ();
    pipeline_stall_controller #(.CNT_W(16), .MEM_TIMEOUT(15)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
    pipeline_stall_controller #(.CNT_W(4),  .MEM_TIMEOUT(15)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));

    task automatic set_in(input logic lu, input logic br, input logic mq, input logic mr, input logic clr);
        a.load_use = lu; a.branch_taken = br; a.mem_req = mq; a.mem_ready = mr; a.stats_clr = clr;
        b.load_use = lu; b.branch_taken = br; b.mem_req = mq; b.mem_ready = mr; b.stats_clr = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_seq();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0);
        rst = 1'b0;
        tick(); tick();
        @(negedge clk);
        checks++; if (a.pc_write !== 1'b0) begin errors++; $display("FAIL rst_held_pc_write got=%0d exp=0", a.pc_write); end
        checks++; if (a.if_id_write !== 1'b0) begin errors++; $display("FAIL rst_held_if_id_write got=%0d exp=0", a.if_id_write); end
        checks++; if (a.pipe_hold !== 1'b1) begin errors++; $display("FAIL rst_held_pipe_hold got=%0d exp=1", a.pipe_hold); end
        checks++; if (a.id_ex_bubble !== 1'b0 || a.mem_wb_bubble !== 1'b0 || a.if_id_flush !== 1'b0) begin errors++; $display("FAIL rst_held_bubbles got=%0d%0d%0d exp=000", a.id_ex_bubble, a.mem_wb_bubble, a.if_id_flush); end
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (a.pc_write !== 1'b1 || a.if_id_write !== 1'b1) begin errors++; $display("FAIL reset_enables got=%0d%0d exp=11", a.pc_write, a.if_id_write); end
        checks++; if (a.pipe_hold !== 1'b0) begin errors++; $display("FAIL reset_pipe_hold got=%0d exp=0", a.pipe_hold); end
        checks++; if (a.state !== 2'b00) begin errors++; $display("FAIL reset_state got=%0d exp=0", a.state); end
        checks++; if (a.stall_cnt !== 16'd0 || a.flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", a.stall_cnt, a.flush_cnt); end
        checks++; if (a.mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_mem_timeout got=%0d exp=0", a.mem_timeout); end
        tick();
    endtask

    task automatic test_load_use();
        rst_seq();
        set_in(1, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (a.pc_write !== 1'b0 || a.if_id_write !== 1'b0) begin errors++; $display("FAIL lu_enables got=%0d%0d exp=00", a.pc_write, a.if_id_write); end
        checks++; if (a.id_ex_bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble got=%0d exp=1", a.id_ex_bubble); end
        checks++; if (a.pipe_hold !== 1'b0 || a.mem_wb_bubble !== 1'b0) begin errors++; $display("FAIL lu_no_hold got=%0d%0d exp=00", a.pipe_hold, a.mem_wb_bubble); end
        tick();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (a.stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", a.stall_cnt); end
        checks++; if (a.pc_write !== 1'b1 || a.state !== 2'b00) begin errors++; $display("FAIL lu_after got=%0d/%0d exp=1/0", a.pc_write, a.state); end
        tick();
    endtask

    task automatic test_priority();
        rst_seq();
        set_in(1, 1, 0, 0, 0);
        @(negedge clk);
        checks++; if (a.if_id_flush !== 1'b0 || a.id_ex_bubble !== 1'b1) begin errors++; $display("FAIL lu_over_branch got=%0d%0d exp=01", a.if_id_flush, a.id_ex_bubble); end
        tick();
        set_in(0, 1, 0, 0, 0);
        @(negedge clk);
        checks++; if (a.flush_cnt !== 16'd0 || a.stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_branch_cnts got=%0d/%0d exp=0/1", a.flush_cnt, a.stall_cnt); end
        checks++; if (a.if_id_flush !== 1'b1 || a.pc_write !== 1'b1 || a.id_ex_bubble !== 1'b0) begin errors++; $display("FAIL branch_flush got=%0d%0d%0d exp=110", a.if_id_flush, a.pc_write, a.id_ex_bubble); end
        tick();
        set_in(0, 0, 1, 1, 0);
        @(negedge clk);
        checks++; if (a.flush_cnt !== 16'd1) begin errors++; $display("FAIL branch_flush_cnt got=%0d exp=1", a.flush_cnt); end
        checks++; if (a.pc_write !== 1'b1 || a.pipe_hold !== 1'b0) begin errors++; $display("FAIL mem_single_cycle got=%0d%0d exp=10", a.pc_write, a.pipe_hold); end
        tick();
        set_in(1, 1, 1, 0, 0);
        @(negedge clk);
        checks++; if (a.pipe_hold !== 1'b1 || a.mem_wb_bubble !== 1'b1 || a.id_ex_bubble !== 1'b0 || a.if_id_flush !== 1'b0) begin errors++; $display("FAIL mem_over_lu got=%0d%0d%0d%0d exp=1100", a.pipe_hold, a.mem_wb_bubble, a.id_ex_bubble, a.if_id_flush); end
        tick();
        set_in(0, 1, 1, 1, 0);
        @(negedge clk);
        checks++; if (a.state !== 2'b01 || a.pipe_hold !== 1'b0 || a.if_id_flush !== 1'b1) begin errors++; $display("FAIL release_branch got=%0d/%0d%0d exp=1/01", a.state, a.pipe_hold, a.if_id_flush); end
        tick();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (a.state !== 2'b00 || a.flush_cnt !== 16'd2 || a.stall_cnt !== 16'd2) begin errors++; $display("FAIL release_after got=%0d/%0d/%0d exp=0/2/2", a.state, a.flush_cnt, a.stall_cnt); end
        tick();
    endtask

    task automatic test_mem_wait();
        rst_seq();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 1, 0, 0);
            @(negedge clk);
            checks++; if (a.pipe_hold !== 1'b1 || a.pc_write !== 1'b0 || a.mem_wb_bubble !== 1'b1) begin errors++; $display("FAIL wait_hold_%0d got=%0d%0d%0d exp=101", i, a.pipe_hold, a.pc_write, a.mem_wb_bubble); end
            checks++; if (a.state !== ((i == 0) ? 2'b00 : 2'b01)) begin errors++; $display("FAIL wait_state_%0d got=%0d exp=%0d", i, a.state, (i == 0) ? 0 : 1); end
            tick();
        end
        set_in(0, 0, 1, 1, 0);
        @(negedge clk);
        checks++; if (a.pipe_hold !== 1'b0 || a.pc_write !== 1'b1 || a.state !== 2'b01) begin errors++; $display("FAIL wait_release got=%0d%0d/%0d exp=01/1", a.pipe_hold, a.pc_write, a.state); end
        tick();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (a.state !== 2'b00 || a.stall_cnt !== 16'd3) begin errors++; $display("FAIL wait_after got=%0d/%0d exp=0/3", a.state, a.stall_cnt); end
        set_in(0, 0, 1, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (a.state !== 2'b01 || a.pipe_hold !== 1'b0) begin errors++; $display("FAIL req_drop got=%0d/%0d exp=1/0", a.state, a.pipe_hold); end
        tick();
        @(negedge clk);
        checks++; if (a.state !== 2'b00 || a.stall_cnt !== 16'd4) begin errors++; $display("FAIL req_drop_after got=%0d/%0d exp=0/4", a.state, a.stall_cnt); end
        set_in(0, 0, 1, 0, 0);
        tick(); tick();
        @(negedge clk) rst = 1'b0;
        #1;
        checks++; if (a.state !== 2'b00 || a.stall_cnt !== 16'd0 || a.pc_write !== 1'b0) begin errors++; $display("FAIL rst_mid_wait got=%0d/%0d/%0d exp=0/0/0", a.state, a.stall_cnt, a.pc_write); end
        set_in(0, 0, 0, 0, 0);
        @(negedge clk) rst = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        rst_seq();
        for (int i = 0; i < 20; i++) begin
            set_in(0, 0, 1, 0, 0);
            @(negedge clk);
            checks++; if (a.pipe_hold !== 1'b1) begin errors++; $display("FAIL to_hold_%0d got=%0d exp=1", i, a.pipe_hold); end
            checks++; if (a.state !== ((i == 0) ? 2'b00 : (i < 16) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL to_state_%0d got=%0d exp=%0d", i, a.state, (i == 0) ? 0 : (i < 16) ? 1 : 2); end
            tick();
        end
        set_in(1, 1, 1, 1, 0);
        @(negedge clk);
        checks++; if (a.state !== 2'b10 || a.mem_timeout !== 1'b1) begin errors++; $display("FAIL to_error got=%0d/%0d exp=2/1", a.state, a.mem_timeout); end
        checks++; if (a.pipe_hold !== 1'b1 || a.pc_write !== 1'b0 || a.if_id_flush !== 1'b0 || a.id_ex_bubble !== 1'b0) begin errors++; $display("FAIL to_error_hold got=%0d%0d%0d%0d exp=1000", a.pipe_hold, a.pc_write, a.if_id_flush, a.id_ex_bubble); end
        checks++; if (a.stall_cnt !== 16'd20) begin errors++; $display("FAIL to_stall_cnt got=%0d exp=20", a.stall_cnt); end
        checks++; if (b.stall_cnt !== 4'd15 || b.mem_timeout !== 1'b1) begin errors++; $display("FAIL to_b_sat got=%0d/%0d exp=15/1", b.stall_cnt, b.mem_timeout); end
        tick();
        rst_seq();
        @(negedge clk);
        checks++; if (a.state !== 2'b00 || a.mem_timeout !== 1'b0 || a.pc_write !== 1'b1) begin errors++; $display("FAIL to_rst_exit got=%0d/%0d/%0d exp=0/0/1", a.state, a.mem_timeout, a.pc_write); end
        tick();
    endtask

    task automatic test_saturate();
        rst_seq();
        for (int i = 0; i < 20; i++) begin
            set_in(0, 1, 0, 0, 0);
            tick();
        end
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (b.flush_cnt !== 4'd15) begin errors++; $display("FAIL sat_b_flush got=%0d exp=15", b.flush_cnt); end
        checks++; if (a.flush_cnt !== 16'd20 || a.stall_cnt !== 16'd0) begin errors++; $display("FAIL sat_a_flush got=%0d/%0d exp=20/0", a.flush_cnt, a.stall_cnt); end
        set_in(1, 1, 0, 0, 1);
        tick();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (b.flush_cnt !== 4'd0 || a.flush_cnt !== 16'd0 || a.stall_cnt !== 16'd0) begin errors++; $display("FAIL clr_wins got=%0d/%0d/%0d exp=0/0/0", b.flush_cnt, a.flush_cnt, a.stall_cnt); end
        set_in(0, 1, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (b.flush_cnt !== 4'd1) begin errors++; $display("FAIL clr_recount got=%0d exp=1", b.flush_cnt); end
        tick();
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0);
        test_reset();
        test_load_use();
        test_priority();
        test_mem_wait();
        test_timeout();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
